// File: rtl/or32_accum_pkg.sv
// Shared definitions for the or32_accum streaming OR-reduction stage.
package or32_accum_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/or32_accum_or32.sv
// or32: 32-bit bitwise OR gate, the datapath of or32_accum.
module or32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = a | b;

endmodule

// File: rtl/or32_accum.sv
// or32_accum: start-triggered, length-counted OR accumulator with a
// valid/ready word input and a single-entry result buffer.
module or32_accum
    import or32_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_all_ones,
    output logic             busy
);

    // The or32 gate fixes the datapath width.
    if (WIDTH != 32) begin : g_width_check
        $error("or32_accum: WIDTH must be 32 while or32 is the datapath");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_or;
    logic [LEN_W-1:0] remaining;
    logic             in_fire;

    or32 u_or32 (
        .a (acc),
        .b (in_data),
        .y (acc_or)
    );

    assign in_fire      = in_valid && in_ready;
    assign out_data     = acc;
    assign out_all_ones = &acc;
    assign busy         = (state != ST_IDLE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs, decoded from state only.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && remaining == LEN_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Accumulator and word counter: cleared on start, updated per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            remaining <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                acc       <= '0;
                remaining <= len;
            end else if (in_fire) begin
                acc       <= acc_or;
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

endmodule
